// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memory subsystem.
// Holds the state encoding used by the instruction/data memory arbiter.
package mips_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

endpackage : mips_pkg

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive D grants made while a fetch is waiting.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   inc_i      : count one more D grant (ignored once saturated)
//   clr_i      : clear the count (wins over inc_i)
//   sat_o      : count has reached MAX_WAIT, the fetch must be served next
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority, increment stops at MAX_WAIT.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CW{1'b0}};
        end else if (inc_i && (count_q != MAX_CNT)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign sat_o = (count_q == MAX_CNT);

endmodule : arb_wait_counter

// File: rtl/mem_arbiter.sv
// Shares one unified memory port between instruction fetch (I, read-only)
// and memory access (D, read/write). D has priority, but after MAX_WAIT
// consecutive D grants with a fetch pending the fetch is forced through.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   i_req/i_addr -> i_ack/i_rdata    : fetch handshake
//   d_req/d_we/d_addr/d_wdata
//                -> d_ack/d_rdata    : data handshake
//   mem_req/mem_we/mem_addr/mem_wdata: registered memory request
//   mem_ack/mem_rdata                : memory completion and read data
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          wait_inc_s;
    logic          wait_clr_s;
    logic          wait_sat_s;
    logic          grant_d_s;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .inc_i (wait_inc_s),
        .clr_i (wait_clr_s),
        .sat_o (wait_sat_s)
    );

    // D wins unless a fetch has already waited out MAX_WAIT D grants.
    assign grant_d_s = d_req & (~i_req | ~wait_sat_s);

    // Arbitration FSM: next state, next memory request and wait-count control.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_inc_s  = 1'b0;
        wait_clr_s  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                mem_req_d = 1'b0;
                if (grant_d_s) begin
                    state_d     = ARB_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Only D grants that make a fetch wait count toward starvation.
                    wait_inc_s  = i_req;
                    wait_clr_s  = ~i_req;
                end else if (i_req) begin
                    state_d     = ARB_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = {DW{1'b0}};
                    wait_clr_s  = 1'b1;
                end else begin
                    wait_clr_s  = 1'b1;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                // The access always runs to completion, even if the requester left.
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d   = state_q;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and memory-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Ack/rdata gating: an abandoned request completes silently.
    always_comb begin
        i_ack   = (state_q == ARB_BUSY_I) & mem_ack & i_req;
        d_ack   = (state_q == ARB_BUSY_D) & mem_ack & d_req;
        i_rdata = i_ack ? mem_rdata : {DW{1'b0}};
        // Store type comes from the latched request, not the live d_we.
        if (d_ack && !mem_we_q) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = {DW{1'b0}};
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%h want=0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%h want=0", mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        total++; if ({i_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {i_ack, d_ack}); end
        total++; if ({i_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {i_rdata, d_rdata}); end
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_mem_req got=%h want=1", mem_req); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_mem_addr got=%h want=40", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fetch_mem_we got=%h want=0", mem_we); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL fetch_mem_wdata got=%h want=0", mem_wdata); end
        total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack got=%h want=0", i_ack); end
        tick();
        total++; if ({mem_req, i_ack} !== 2'b10) begin bad++; $display("FAIL fetch_wait got=%b want=10", {mem_req, i_ack}); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h2008000A;
        #1;
        total++; if (i_ack !== 1'b1) begin bad++; $display("FAIL fetch_ack got=%h want=1", i_ack); end
        total++; if (i_rdata !== 32'h2008000A) begin bad++; $display("FAIL fetch_rdata got=%h want=2008000a", i_rdata); end
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL fetch_d_ack got=%h want=0", d_ack); end
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        #1;
        total++; if ({mem_req, i_ack, d_ack} !== 3'b000) begin bad++; $display("FAIL fetch_done got=%b want=000", {mem_req, i_ack, d_ack}); end
        total++; if (i_rdata !== 32'h0) begin bad++; $display("FAIL fetch_rdata_gate got=%h want=0", i_rdata); end
        tick();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        tick();
        total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL store_req_we got=%b want=11", {mem_req, mem_we}); end
        total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_wdata got=%h want=deadbeef", mem_wdata); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL store_addr got=%h want=100", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1;
        total++; if (d_ack !== 1'b1) begin bad++; $display("FAIL store_ack got=%h want=1", d_ack); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL store_rdata got=%h want=0", d_rdata); end
        tick();
        // Back-to-back: load presented the cycle right after the store ack.
        mem_ack = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        tick();
        total++; if ({mem_req, mem_we} !== 2'b10) begin bad++; $display("FAIL load_req_we got=%b want=10", {mem_req, mem_we}); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL load_addr got=%h want=100", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (d_ack !== 1'b1) begin bad++; $display("FAIL load_ack got=%h want=1", d_ack); end
        total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h want=deadbeef", d_rdata); end
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [9:0] exp_i;
        exp_i = 10'b1000010000; // bit k set: grant k goes to I
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            tick();
            mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(k);
            #1;
            total++;
            if ({i_ack, d_ack} !== {exp_i[k], ~exp_i[k]}) begin
                bad++; $display("FAIL grant_%0d got i/d=%b want=%b", k, {i_ack, d_ack}, {exp_i[k], ~exp_i[k]});
            end
            total++;
            if (mem_addr !== (exp_i[k] ? 32'h200 : 32'h300)) begin
                bad++; $display("FAIL grant_addr_%0d got=%h want=%h", k, mem_addr, exp_i[k] ? 32'h200 : 32'h300);
            end
            tick();
            mem_ack = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_squash();
        i_req = 1'b1; i_addr = 32'h80;
        tick();
        total++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin bad++; $display("FAIL squash_grant got=%b/%h want=1/80", mem_req, mem_addr); end
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
        tick();
        total++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin bad++; $display("FAIL squash_hold1 got=%b/%h want=1/80", mem_req, mem_addr); end
        tick();
        total++; if ({mem_req, i_ack, d_ack} !== 3'b100) begin bad++; $display("FAIL squash_hold2 got=%b want=100", {mem_req, i_ack, d_ack}); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        #1;
        total++; if ({i_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL squash_no_ack got=%b want=00", {i_ack, d_ack}); end
        total++; if ({i_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL squash_rdata got=%h want=0", {i_rdata, d_rdata}); end
        tick();
        mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL squash_idle got=%h want=0", mem_req); end
        tick();
        total++; if ({mem_req, mem_addr} !== {1'b1, 32'h180}) begin bad++; $display("FAIL squash_d_grant got=%b/%h want=1/180", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h77;
        #1;
        total++; if ({d_ack, d_rdata} !== {1'b1, 32'h77}) begin bad++; $display("FAIL squash_d_ack got=%b/%h want=1/77", d_ack, d_rdata); end
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h240; d_wdata = 32'hCAFEF00D;
        tick();
        total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL rst_mid_grant got=%b want=11", {mem_req, mem_we}); end
        reset = 1'b1;
        tick();
        reset = 1'b0; d_req = 1'b0;
        #1;
        total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_mid_req_we got=%b want=00", {mem_req, mem_we}); end
        total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", {mem_addr, mem_wdata}); end
        d_req = 1'b1;
        mem_ack = 1'b1;
        #1;
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL rst_mid_late_ack got=%h want=0", d_ack); end
        d_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%h want=0", mem_req); end
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        #1;
        total++; if ({i_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL stray_acks got=%b want=00", {i_ack, d_ack}); end
        tick();
        mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stray_mem_req got=%h want=0", mem_req); end
        // Still in IDLE: a fresh fetch is granted on the next edge.
        i_req = 1'b1; i_addr = 32'h44;
        tick();
        total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h44}) begin bad++; $display("FAIL stray_then_fetch got=%b/%h want=10/44", {mem_req, mem_we}, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        #1;
        total++; if ({i_ack, i_rdata} !== {1'b1, 32'h1234}) begin bad++; $display("FAIL stray_fetch_ack got=%b/%h want=1/1234", i_ack, i_rdata); end
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_squash();
        test_reset_mid_access();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter
